bp_cce_mshr_sched: RTL

BP_CCE_MSHR_SCHED -- requirements
Module: bp_cce_mshr_sched

---
 rtl/bp_cce_pkg.sv | 16 +
 rtl/bsg_arb_round_robin.sv | 47 ++++
 rtl/bsg_priority_encode.sv | 25 ++
 rtl/bp_cce_mshr_sched.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/bp_cce_pkg.sv
// rtl/bp_cce_pkg.sv - shared CCE types and helpers for the MSHR scheduler
package bp_cce_pkg;

    typedef enum logic [1:0] {
        e_slot_free   = 2'd0,
        e_slot_active = 2'd1,
        e_slot_wait   = 2'd2,
        e_slot_ready  = 2'd3
    } bp_cce_mshr_slot_state_e;

    // clog2 that never returns 0, so a 1-entry index still gets a 1-bit field
    function automatic int safe_clog2(input int x);
        return (x <= 1) ? 1 : $clog2(x);
    endfunction

endpackage

// File: rtl/bsg_arb_round_robin.sv
// rtl/bsg_arb_round_robin.sv - round-robin arbiter, pointer moves past each accepted grant
module bsg_arb_round_robin
    import bp_cce_pkg::*;
#(
    parameter int width_p = 4,
    parameter int lg_w_lp = safe_clog2(width_p)
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic [width_p-1:0] reqs_i,
    output logic [width_p-1:0] grants_o,
    input  logic               yumi_i
);

    logic [lg_w_lp-1:0] ptr_q, ptr_d;
    logic [lg_w_lp-1:0] gidx;
    logic               found;
    int                 scan_idx;

    // first requester at or after the pointer, wrapping around
    always_comb begin
        grants_o = '0;
        found    = 1'b0;
        gidx     = '0;
        scan_idx = 0;
        for (int k = 0; k < width_p; k++) begin
            scan_idx = int'(ptr_q) + k;
            if (scan_idx >= width_p) scan_idx = scan_idx - width_p;
            if (!found && reqs_i[scan_idx]) begin
                grants_o[scan_idx] = 1'b1;
                gidx               = lg_w_lp'(scan_idx);
                found              = 1'b1;
            end
        end
        ptr_d = ptr_q;
        if (yumi_i && found) begin
            ptr_d = (int'(gidx) == width_p - 1) ? '0 : gidx + lg_w_lp'(1);
        end
    end

    // pointer register
    always_ff @(posedge clk_i) begin
        if (reset_i) ptr_q <= '0;
        else         ptr_q <= ptr_d;
    end

endmodule

// File: rtl/bsg_priority_encode.sv
// rtl/bsg_priority_encode.sv - lowest-index set bit to binary index
module bsg_priority_encode
    import bp_cce_pkg::*;
#(
    parameter int width_p   = 4,
    parameter int addr_w_lp = safe_clog2(width_p)
) (
    input  logic [width_p-1:0]   i,
    output logic [addr_w_lp-1:0] addr_o,
    output logic                 v_o
);

    // scan high to low so the lowest set bit is the last one written
    always_comb begin
        addr_o = '0;
        v_o    = 1'b0;
        for (int k = width_p - 1; k >= 0; k--) begin
            if (i[k]) begin
                addr_o = addr_w_lp'(k);
                v_o    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/bp_cce_mshr_sched.sv
// rtl/bp_cce_mshr_sched.sv - MSHR slot scheduler feeding the CCE register block restore
module bp_cce_mshr_sched
    import bp_cce_pkg::*;
#(
    parameter int num_mshr_p            = 4,
    parameter int paddr_width_p         = 40,
    parameter int block_size_in_bytes_p = 64,
    parameter int lg_block_size_in_bytes_lp = safe_clog2(block_size_in_bytes_p),
    parameter int lg_num_mshr_lp        = safe_clog2(num_mshr_p),
    parameter int count_width_lp        = $clog2(num_mshr_p + 1)
) (
    input  logic                      clk_i,
    input  logic                      reset_i,
    input  logic                      alloc_v_i,
    input  logic [paddr_width_p-1:0]  alloc_addr_i,
    output logic                      alloc_ready_o,
    input  logic                      park_v_i,
    input  logic                      free_v_i,
    input  logic                      mem_resp_v_i,
    input  logic [lg_num_mshr_lp-1:0] mem_resp_id_i,
    output logic                      active_v_o,
    output logic [lg_num_mshr_lp-1:0] active_id_o,
    output logic                      restore_v_o,
    output logic [count_width_lp-1:0] count_o
);

    localparam int baddr_width_lp = paddr_width_p - lg_block_size_in_bytes_lp;

    bp_cce_mshr_slot_state_e    state_q [num_mshr_p];
    bp_cce_mshr_slot_state_e    state_d [num_mshr_p];
    logic [baddr_width_lp-1:0]  addr_q  [num_mshr_p];
    logic [baddr_width_lp-1:0]  addr_d  [num_mshr_p];

    logic                       active_v_q, active_v_d;
    logic [lg_num_mshr_lp-1:0]  active_id_q, active_id_d;
    logic                       restore_v_q, restore_v_d;
    logic [count_width_lp-1:0]  count_q, count_d;

    logic [num_mshr_p-1:0]      free_vec, ready_vec, grants;
    logic                       any_ready, any_free, addr_hit;
    logic [baddr_width_lp-1:0]  alloc_baddr;
    logic [lg_num_mshr_lp-1:0]  alloc_id, grant_id;
    logic                       alloc_fire, grant_v;

    assign alloc_baddr = alloc_addr_i[paddr_width_p-1:lg_block_size_in_bytes_lp];

    // slot summaries and the same-block conflict check against live slots
    always_comb begin
        free_vec  = '0;
        ready_vec = '0;
        addr_hit  = 1'b0;
        for (int k = 0; k < num_mshr_p; k++) begin
            free_vec[k]  = (state_q[k] == e_slot_free);
            ready_vec[k] = (state_q[k] == e_slot_ready);
            if (state_q[k] != e_slot_free && addr_q[k] == alloc_baddr) addr_hit = 1'b1;
        end
        any_ready = |ready_vec;
    end

    bsg_priority_encode #(.width_p(num_mshr_p)) free_pe (
        .i      (free_vec),
        .addr_o (alloc_id),
        .v_o    (any_free)
    );

    // resumed requests get the register block before any new request
    assign grant_v = !reset_i && !active_v_q && any_ready;

    bsg_arb_round_robin #(.width_p(num_mshr_p)) ready_rr (
        .clk_i    (clk_i),
        .reset_i  (reset_i),
        .reqs_i   (ready_vec),
        .grants_o (grants),
        .yumi_i   (grant_v)
    );

    assign alloc_ready_o = !reset_i && !active_v_q && !any_ready && any_free && !addr_hit;
    assign alloc_fire    = alloc_v_i && alloc_ready_o;

    // one-hot grant to binary slot id
    always_comb begin
        grant_id = '0;
        for (int k = 0; k < num_mshr_p; k++) begin
            if (grants[k]) grant_id = lg_num_mshr_lp'(k);
        end
    end

    // per-slot transitions; free beats park, a response during park skips WAIT
    always_comb begin
        for (int k = 0; k < num_mshr_p; k++) begin
            state_d[k] = state_q[k];
            addr_d[k]  = addr_q[k];
            if (active_v_q && int'(active_id_q) == k) begin
                if (free_v_i) begin
                    state_d[k] = e_slot_free;
                end else if (park_v_i) begin
                    state_d[k] = (mem_resp_v_i && int'(mem_resp_id_i) == k) ? e_slot_ready : e_slot_wait;
                end
            end
            if (state_q[k] == e_slot_wait && mem_resp_v_i && int'(mem_resp_id_i) == k) begin
                state_d[k] = e_slot_ready;
            end
            if (grant_v && grants[k]) begin
                state_d[k] = e_slot_active;
            end
            if (alloc_fire && int'(alloc_id) == k) begin
                state_d[k] = e_slot_active;
                addr_d[k]  = alloc_baddr;
            end
        end
    end

    // registered ownership, restore pulse and occupancy count
    always_comb begin
        active_v_d  = active_v_q;
        active_id_d = active_id_q;
        restore_v_d = 1'b0;
        if (grant_v) begin
            active_v_d  = 1'b1;
            active_id_d = grant_id;
            restore_v_d = 1'b1;
        end else if (alloc_fire) begin
            active_v_d  = 1'b1;
            active_id_d = alloc_id;
        end else if (active_v_q && (park_v_i || free_v_i)) begin
            active_v_d  = 1'b0;
        end
        count_d = '0;
        for (int k = 0; k < num_mshr_p; k++) begin
            if (state_d[k] != e_slot_free) count_d = count_d + count_width_lp'(1);
        end
    end

    // state registers with synchronous reset discarding all outstanding work
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            for (int k = 0; k < num_mshr_p; k++) begin
                state_q[k] <= e_slot_free;
                addr_q[k]  <= '0;
            end
            active_v_q  <= 1'b0;
            active_id_q <= '0;
            restore_v_q <= 1'b0;
            count_q     <= '0;
        end else begin
            for (int k = 0; k < num_mshr_p; k++) begin
                state_q[k] <= state_d[k];
                addr_q[k]  <= addr_d[k];
            end
            active_v_q  <= active_v_d;
            active_id_q <= active_id_d;
            restore_v_q <= restore_v_d;
            count_q     <= count_d;
        end
    end

    assign active_v_o  = active_v_q;
    assign active_id_o = active_id_q;
    assign restore_v_o = restore_v_q;
    assign count_o     = count_q;

endmodule
